// File: rtl/boot_word_deserializer_pkg.sv
// Shared bootloader definitions: load-window state encoding and default geometry.
package boot_word_deserializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_FULL = 2'd2
  } boot_state_e;

  localparam int unsigned BOOT_DATA_WIDTH      = 32;
  localparam int unsigned BOOT_ADDR_WIDTH      = 12;
  localparam int unsigned BOOT_TIMEOUT_CYCLES  = 50000;

endpackage

// File: rtl/boot_word_deserializer_sync_edge_detect.sv
// Multi-flop synchroniser with a rising-edge pulse on the synchronised level.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/boot_word_deserializer.sv
// Serial bootloader front end: assembles MSB-first words and drives the ROM write port.
module boot_word_deserializer
  import boot_word_deserializer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = BOOT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = BOOT_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = BOOT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  ser_clk,
  input  logic                  ser_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  overflow
);

  localparam int unsigned CNT_W  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  boot_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic                  tout_q, tout_d;
  logic                  ovf_q, ovf_d;

  logic                  ser_rise, ser_bit;
  logic                  unused_clk_level, unused_data_rise;
  logic                  word_done;
  logic [ADDR_WIDTH:0]   words_inc;

  // Both pins share the same synchroniser depth so data lines up with the detected edge.
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk_i   (clk),
    .rst_i   (reset),
    .d_i     (ser_clk),
    .level_o (unused_clk_level),
    .rise_o  (ser_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk_i   (clk),
    .rst_i   (reset),
    .d_i     (ser_data),
    .level_o (ser_bit),
    .rise_o  (unused_data_rise)
  );

  assign word_done = (bit_cnt_q == CNT_W'(DATA_WIDTH));
  assign words_inc = words_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    idle_d    = idle_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    words_d   = words_q;
    tout_d    = tout_q;
    ovf_d     = ovf_q;

    // Retire the write strobed last cycle; the address saturates at the last slot.
    if (wr_en_q) begin
      words_d = words_inc;
      if (words_inc != CAPACITY) begin
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        idle_d    = '0;
        if (enable) begin
          words_d   = '0;
          wr_addr_d = '0;
          tout_d    = 1'b0;
          ovf_d     = 1'b0;
          state_d   = ST_RECV;
        end
      end

      ST_RECV: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          idle_d    = '0;
        end else if (wr_en_q && (words_inc == CAPACITY)) begin
          state_d   = ST_FULL;
          bit_cnt_d = '0;
          idle_d    = '0;
        end else begin
          if (ser_rise) begin
            shift_d   = {shift_q[DATA_WIDTH-2:0], ser_bit};
            bit_cnt_d = word_done ? CNT_W'(1) : bit_cnt_q + 1'b1;
            idle_d    = '0;
          end else if (word_done) begin
            bit_cnt_d = '0;
            idle_d    = '0;
          end else if (bit_cnt_q != '0) begin
            if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
              bit_cnt_d = '0;
              idle_d    = '0;
              tout_d    = 1'b1;
            end else begin
              idle_d = idle_q + 1'b1;
            end
          end else begin
            idle_d = '0;
          end

          if (word_done) begin
            wr_en_d   = 1'b1;
            wr_data_d = shift_q;
          end
        end
      end

      ST_FULL: begin
        bit_cnt_d = '0;
        idle_d    = '0;
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (ser_rise) begin
          ovf_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      idle_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      words_q   <= '0;
      tout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      idle_q    <= idle_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      words_q   <= words_d;
      tout_q    <= tout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign words_loaded = words_q;
  assign busy         = (bit_cnt_q != '0);
  assign timeout_err  = tout_q;
  assign overflow     = ovf_q;

endmodule

// File: doc/boot_word_deserializer.md
Name: boot_word_deserializer

Overview:
- Serial-to-word front end of the bootloader path. Sits directly upstream of the instruction ROM write port.
- Samples an externally driven serial clock/data pair in the core clock domain and assembles MSB-first 32-bit words.
- Emits one write strobe per word with an auto-incrementing ROM address.
- Only active while the load window is open, i.e. the CPU is held in reset. Adds resynchronisation on idle timeout and overflow protection.

Parameters:
- ADDR_WIDTH, 12, width of ROM word address; capacity 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, bits per word assembled before a write.
- SYNC_STAGES, 2, flip-flop depth of input synchronisers (min 2).
- TIMEOUT_CYCLES, 50000, clk cycles without a serial edge before a partial word is discarded.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  load window open (tied to CPU-in-reset); synchronous to clk.
- ser_clk  input  1  external serial bit strobe; asynchronous; data valid on rising edge.
- ser_data  input  1  external serial data; asynchronous.
- wr_en  output  1  one-cycle ROM write strobe.
- wr_addr  output  ADDR_WIDTH  ROM address for current wr_data.
- wr_data  output  DATA_WIDTH  assembled word.
- words_loaded  output  ADDR_WIDTH+1  count of words written this session.
- busy  output  1  high while a partial word is in progress (bit_cnt != 0).
- timeout_err  output  1  sticky: a partial word was discarded this session.
- overflow  output  1  sticky: a word arrived after capacity was reached.

Behaviour:
- Reset values (async, immediate): wr_en=0, wr_addr=0, wr_data=0, words_loaded=0, busy=0, timeout_err=0, overflow=0. Synchroniser chains and all internal state also clear to 0, so state = IDLE and the edge-detect history is 0.
- Synchronisers: ser_clk and ser_data each pass through SYNC_STAGES flops. A rising edge is detected when the synced ser_clk is 1 and the previous synced value is 0.
  - Data is taken from the synced ser_data at the same stage depth, so it is aligned with the clk edge.
  - Pin edge to shift-register update latency: SYNC_STAGES+1 clk cycles.
  - The external host must hold ser_data stable for at least SYNC_STAGES+2 clk cycles around the ser_clk rising edge.
- Shift: on a detected edge in RECV, shift_reg <= {shift_reg[DATA_WIDTH-2:0], bit} and bit_cnt++.
- Word complete on the DATA_WIDTH-th bit. On the next clk:
  - wr_data <= shift_reg;
  - wr_en = 1 for exactly one cycle with wr_addr = words_loaded[ADDR_WIDTH-1:0];
  - bit_cnt <= 0.
  - The cycle after the wr_en pulse, wr_addr and words_loaded increment. wr_data holds until the next word.
- States:
  - IDLE: enable=0. Edges ignored, bit_cnt held at 0. On enable 0->1, clear words_loaded, wr_addr, timeout_err and overflow, then go to RECV.
  - RECV: assemble words as above. After a write brings words_loaded to 2^ADDR_WIDTH, go to FULL. If enable drops, go to IDLE.
  - FULL: no further writes. Any detected edge sets overflow; wr_addr holds at the last address. If enable drops, go to IDLE.
- Timeout: an idle counter clears on every detected edge and counts while bit_cnt != 0. At TIMEOUT_CYCLES:
  - bit_cnt <= 0 and the partial word is discarded (no write);
  - timeout_err <= 1.
  - The counter does not run while bit_cnt == 0.
- enable drop mid-word: the partial word is discarded, no wr_en is issued, and bit_cnt clears. words_loaded, timeout_err and overflow retain their values until the next enable rise.
- Simultaneous word completion and enable drop: the write does NOT occur. enable is sampled first.
- Simultaneous timeout and edge: the edge wins. The bit is shifted and the timeout counter clears.
- Reset mid-word: everything clears immediately. No partial write.
- wr_en is never asserted in IDLE or FULL, and never twice for one word.

Decomposition:
- Shared bootloader package:
  - state encoding (IDLE, RECV, FULL);
  - default word width (32) and ROM address width (12);
  - default timeout constant.
- One natural sub-module, sync_edge_detect: a parameterised SYNC_STAGES synchroniser plus rising-edge pulse. It is instantiated for ser_clk (edge output used) and ser_data (level output used), so the two paths have identical delay.

Test Plan:
- Reset, enable=1, shift 0xDEADBEEF MSB-first -> single wr_en pulse with wr_addr=0, wr_data=0xDEADBEEF; words_loaded=1; busy=0.
- Three words 0x00000001, 0x80000000, 0xFFFFFFFF -> wr_en at addresses 0, 1, 2 with those data; words_loaded=3.
- 17 bits, then idle TIMEOUT_CYCLES (bench uses 100) -> no wr_en, timeout_err=1, busy=0. Then send 0x12345678 -> written at wr_addr=0.
- ADDR_WIDTH=2, 5 words -> writes at addresses 0..3 only; overflow=1 after 5th word bits start; words_loaded=4.
- enable drops after 20 bits, then rises, send 0xCAFEF00D -> no write before the drop; after the rise the write lands at wr_addr=0 with flags cleared.
- Assert reset at bit 31 of a word -> no wr_en, all outputs 0 immediately. After release with enable=1, the next full word is written at address 0.
